imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Host-side writer for the instruction memory that the CPU fetches from.
- Accepts a stream of 9-bit machine-code words over a valid/ready handshake and writes them to sequential imem addresses from 0.
- Holds the CPU in reset while loading, then releases it and counts run cycles until the CPU raises done or a timeout expires.
- Sits between the testbench/host and the top-level CPU; drives the imem write port and the CPU reset.

Parameters:
- IW, 9, instruction word width.
- AW, 8, imem address width (matches PC).
- DEPTH, 256, number of imem words; must be <= 2**AW.
- MAX_CYC, 16'hFFFF, run-cycle limit before timeout.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE, TIMEOUT or ERR.
- in_valid  in  1  host word valid.
- in_data  in  IW  host instruction word.
- in_last  in  1  marks the final word of the program; qualified by in_valid.
- in_ready  out  1  loader can accept a word.
- im_we  out  1  imem write enable.
- im_addr  out  AW  imem write address.
- im_din  out  IW  imem write data.
- cpu_reset  out  1  active-high reset to the CPU.
- cpu_done  in  1  CPU done flag.
- busy  out  1  high in LOAD, RELEASE or RUN.
- state_o  out  3  current state encoding.
- word_cnt  out  AW+1  words written in the last load.
- run_cyc  out  16  CPU cycles counted in RUN.

Behaviour:
- States: IDLE=0, LOAD=1, RELEASE=2, RUN=3, DONE=4, TIMEOUT=5, ERR=6.
- Reset (reset==0 at the clock edge):
  - state=IDLE, in_ready=0, im_we=0, im_addr=0, im_din=0.
  - cpu_reset=1, word_cnt=0, run_cyc=0.
  - Reset mid-load or mid-run aborts immediately; no further writes occur.
- IDLE:
  - cpu_reset=1.
  - start → LOAD; clears the address counter, word_cnt and run_cyc.
- LOAD:
  - in_ready=1 combinationally while in LOAD.
  - A handshake (in_valid & in_ready) registers im_we=1, im_addr=addr and im_din=in_data on the next edge.
  - im_we is a registered one-cycle pulse per word (1-cycle write latency).
  - addr and word_cnt increment per accepted word.
  - No handshake → im_we=0 on the next cycle.
  - Handshake with in_last=1 → RELEASE.
  - Handshake at addr==DEPTH-1 with in_last=0 → ERR; that last word is still written.
  - in_last at addr==DEPTH-1 → RELEASE (exact fill is legal).
  - start is ignored in LOAD.
- RELEASE:
  - Lasts exactly one cycle with cpu_reset=1, so the CPU sees the final write committed with PC at 0.
  - Then → RUN.
- RUN:
  - cpu_reset=0.
  - run_cyc increments each cycle in RUN, including the cycle cpu_done is sampled high.
  - cpu_done=1 → DONE.
  - If run_cyc==MAX_CYC-1 and cpu_done=0 → TIMEOUT.
  - If both conditions hit in the same cycle, DONE wins.
- DONE / TIMEOUT:
  - cpu_reset=1; run_cyc and word_cnt hold.
  - start → LOAD.
- ERR:
  - cpu_reset=1, in_ready=0.
  - start → LOAD.
- in_ready=0 in every state except LOAD.
- busy=1 in LOAD, RELEASE and RUN; 0 otherwise.
- Counters do not wrap:
  - word_cnt maximum is DEPTH.
  - run_cyc maximum is MAX_CYC.

Decomposition:
- Add to the shared definitions package: typedef enum logic[2:0] ld_state_t {IDLE, LOAD, RELEASE, RUN, DONE, TIMEOUT, ERR}.
- Add a constant kLD_MAXCYC.
- One natural sub-module: ld_counter, a parameterised width counter with clear, enable and terminal-count flag.
  - Used twice: once for address/word_cnt, once for run_cyc.
- The top-level test harness instantiates imem_loader alongside top.
  - imem gains a write port (we, waddr, din).
  - top's reset is driven from cpu_reset.

Test Plan:
- Basic load:
  - Stimulus: reset low 2 cycles, start; stream 9'h1A3, 9'h0F0, 9'h100 (last) with in_valid held high.
  - Response: im_we pulses at addr 0,1,2 with that data; word_cnt=3; RELEASE for 1 cycle; then cpu_reset=0.
- Back-pressure gaps:
  - Stimulus: in_valid toggles 1,0,0,1,1(last).
  - Response: exactly 3 writes at addr 0,1,2; im_we=0 on the cycles after gaps.
- Run to done:
  - Stimulus: after load, assert cpu_done on the 10th RUN cycle.
  - Response: state DONE, run_cyc=10, cpu_reset=1.
- Overflow:
  - Stimulus: DEPTH=4; send 4 words with no in_last.
  - Response: writes at addr 0..3, state ERR, in_ready=0; then start → LOAD with word_cnt=0.
- Timeout:
  - Stimulus: MAX_CYC=16, cpu_done held 0.
  - Response: TIMEOUT after 16 RUN cycles, run_cyc=15.
  - Stimulus: same, but cpu_done=1 on that same cycle.
  - Response: DONE.
- Reset mid-operation:
  - Stimulus: reset low during LOAD after 2 words, and separately during RUN.
  - Response: next edge gives IDLE, im_we=0, cpu_reset=1, counters 0; start is ignored while in LOAD.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// the default run-cycle limit and a start-qualification helper.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        DONE    = 3'd4,
        TIMEOUT = 3'd5,
        ERR     = 3'd6
    } ld_state_t;

    localparam logic [15:0] kLD_MAXCYC = 16'hFFFF;

    // A new load may only begin from a resting state.
    function automatic logic ld_start_ok(input logic [2:0] s);
        return (s == IDLE) || (s == DONE) || (s == TIMEOUT) || (s == ERR);
    endfunction

endpackage

// File: rtl/imem_loader_ld_counter.sv
// Saturating up-counter with synchronous clear, enable and a terminal-count
// flag; used for the imem address/word count and for the run-cycle count.
module ld_counter #(
    parameter int          W   = 8,
    parameter int unsigned TC  = 255,
    parameter int unsigned MAX = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != W'(MAX))) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == W'(TC));

endmodule

// File: rtl/imem_loader.sv
// Host-side imem writer: streams words into sequential imem addresses while
// holding the CPU in reset, then releases it and times its run.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          IW      = 9,
    parameter int          AW      = 8,
    parameter int          DEPTH   = 256,
    parameter logic [15:0] MAX_CYC = kLD_MAXCYC
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [IW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [IW-1:0] im_din,
    output logic          cpu_reset,
    input  logic          cpu_done,
    output logic          busy,
    output logic [2:0]    state_o,
    output logic [AW:0]   word_cnt,
    output logic [15:0]   run_cyc
);

    localparam logic [2:0] S_IDLE    = IDLE;
    localparam logic [2:0] S_LOAD    = LOAD;
    localparam logic [2:0] S_RELEASE = RELEASE;
    localparam logic [2:0] S_RUN     = RUN;
    localparam logic [2:0] S_DONE    = DONE;
    localparam logic [2:0] S_TIMEOUT = TIMEOUT;
    localparam logic [2:0] S_ERR     = ERR;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic          hs;
    logic          ld_clr;
    logic          addr_tc;
    logic          run_tc;
    logic          run_en;
    logic [AW-1:0] addr;

    assign in_ready  = (state == S_LOAD);
    assign busy      = (state == S_LOAD) || (state == S_RELEASE) || (state == S_RUN);
    assign cpu_reset = (state != S_RUN);
    assign state_o   = state;

    assign hs     = in_valid & in_ready;
    assign ld_clr = start & ld_start_ok(state);
    assign addr   = word_cnt[AW-1:0];

    // The timeout cycle itself is not counted; a done cycle always is.
    assign run_en = (state == S_RUN) && (cpu_done || !run_tc);

    ld_counter #(
        .W   (AW + 1),
        .TC  (DEPTH - 1),
        .MAX (DEPTH)
    ) u_word_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (ld_clr),
        .en    (hs),
        .cnt   (word_cnt),
        .tc    (addr_tc)
    );

    ld_counter #(
        .W   (16),
        .TC  (32'(MAX_CYC) - 1),
        .MAX (32'(MAX_CYC))
    ) u_run_cyc (
        .clk   (clk),
        .reset (reset),
        .clr   (ld_clr),
        .en    (run_en),
        .cnt   (run_cyc),
        .tc    (run_tc)
    );

    // NOTE: state_nxt gets a default before the case so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_TIMEOUT, S_ERR: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (hs) begin
                    if (in_last)      state_nxt = S_RELEASE;
                    else if (addr_tc) state_nxt = S_ERR;
                end
            end
            S_RELEASE: state_nxt = S_RUN;
            S_RUN: begin
                if (cpu_done)    state_nxt = S_DONE;
                else if (run_tc) state_nxt = S_TIMEOUT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Write port is registered: one-cycle latency, one im_we pulse per word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            im_we   <= 1'b0;
            im_addr <= '0;
            im_din  <= '0;
        end else begin
            state <= state_nxt;
            im_we <= hs;
            if (hs) begin
                im_addr <= addr;
                im_din  <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: reset, directed vector tables, corner
// sequences and randomized programs against a transaction-level model.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int T_DEPTH  = 4;
    localparam int T_MAXCYC = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [8:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [8:0]  im_din;
    logic        cpu_reset;
    logic        cpu_done;
    logic        busy;
    logic [2:0]  state_o;
    logic [8:0]  word_cnt;
    logic [15:0] run_cyc;

    int tests = 0;
    int fails = 0;
    int run_seen = 0;
    logic [7:0] got_addr [$];
    logic [8:0] got_data [$];

    imem_loader #(
        .IW      (9),
        .AW      (8),
        .DEPTH   (T_DEPTH),
        .MAX_CYC (16'(T_MAXCYC))
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_din    (im_din),
        .cpu_reset (cpu_reset),
        .cpu_done  (cpu_done),
        .busy      (busy),
        .state_o   (state_o),
        .word_cnt  (word_cnt),
        .run_cyc   (run_cyc)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        start;
        logic        valid;
        logic [8:0]  data;
        logic        last;
        logic [2:0]  e_state;
        logic        e_we;
        logic [7:0]  e_addr;
        logic [8:0]  e_din;
        logic        e_ready;
        logic        e_cr;
        logic [8:0]  e_wc;
        logic [15:0] e_rc;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (im_we) begin
            got_addr.push_back(im_addr);
            got_data.push_back(im_din);
        end
        if (!cpu_reset) run_seen++;
    endtask

    task automatic apply_vec(input int i);
        vec_t v;
        v = vecs[i];
        start    = v.start;
        in_valid = v.valid;
        in_data  = v.data;
        in_last  = v.last;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check($sformatf("v%0d state", i), state_o, v.e_state);
        check($sformatf("v%0d im_we", i), im_we, v.e_we);
        check($sformatf("v%0d im_addr", i), im_addr, v.e_addr);
        check($sformatf("v%0d im_din", i), im_din, v.e_din);
        check($sformatf("v%0d in_ready", i), in_ready, v.e_ready);
        check($sformatf("v%0d cpu_reset", i), cpu_reset, v.e_cr);
        check($sformatf("v%0d word_cnt", i), word_cnt, v.e_wc);
        check($sformatf("v%0d run_cyc", i), run_cyc, v.e_rc);
    endtask

    task automatic load_prog(input int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = 9'($urandom);
            in_last  = (k == n - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        int n, done_at, sent, nexp;
        logic [2:0]  e_state;
        logic [8:0]  e_wc;
        logic [15:0] e_rc;
        int          e_run;
        logic [8:0]  words [T_DEPTH];

        //            start valid data    last state    we addr din     rdy cr wc    rc
        vecs[0]  = '{1'b1, 1'b0, 9'h000, 1'b0, LOAD,    0, 8'd0, 9'h000, 1, 1, 9'd0, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 9'h1A3, 1'b0, LOAD,    1, 8'd0, 9'h1A3, 1, 1, 9'd1, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 9'h0F0, 1'b0, LOAD,    1, 8'd1, 9'h0F0, 1, 1, 9'd2, 16'd0};
        vecs[3]  = '{1'b0, 1'b1, 9'h100, 1'b1, RELEASE, 1, 8'd2, 9'h100, 0, 1, 9'd3, 16'd0};
        vecs[4]  = '{1'b0, 1'b0, 9'h000, 1'b0, RUN,     0, 8'd2, 9'h100, 0, 0, 9'd3, 16'd0};
        // Back-pressure: valid pattern 1,0,0,1,1(last), restarting from DONE.
        vecs[5]  = '{1'b1, 1'b0, 9'h000, 1'b0, LOAD,    0, 8'd2, 9'h100, 1, 1, 9'd0, 16'd0};
        vecs[6]  = '{1'b0, 1'b1, 9'h055, 1'b0, LOAD,    1, 8'd0, 9'h055, 1, 1, 9'd1, 16'd0};
        vecs[7]  = '{1'b0, 1'b0, 9'h0EE, 1'b0, LOAD,    0, 8'd0, 9'h055, 1, 1, 9'd1, 16'd0};
        vecs[8]  = '{1'b0, 1'b0, 9'h0EE, 1'b1, LOAD,    0, 8'd0, 9'h055, 1, 1, 9'd1, 16'd0};
        vecs[9]  = '{1'b0, 1'b1, 9'h0AA, 1'b0, LOAD,    1, 8'd1, 9'h0AA, 1, 1, 9'd2, 16'd0};
        vecs[10] = '{1'b0, 1'b1, 9'h1FF, 1'b1, RELEASE, 1, 8'd2, 9'h1FF, 0, 1, 9'd3, 16'd0};
        vecs[11] = '{1'b0, 1'b0, 9'h000, 1'b0, RUN,     0, 8'd2, 9'h1FF, 0, 0, 9'd3, 16'd0};

        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; cpu_done = 1'b0;
        tick();
        tick();
        check("rst state", state_o, IDLE);
        check("rst im_we", im_we, 0);
        check("rst im_addr", im_addr, 0);
        check("rst im_din", im_din, 0);
        check("rst in_ready", in_ready, 0);
        check("rst cpu_reset", cpu_reset, 1);
        check("rst word_cnt", word_cnt, 0);
        check("rst run_cyc", run_cyc, 0);
        check("rst busy", busy, 0);
        reset = 1'b1;

        for (int i = 0; i <= 4; i++) apply_vec(i);

        // cpu_done on the 10th RUN cycle.
        for (int c = 1; c <= 10; c++) begin
            cpu_done = (c == 10);
            tick();
            if (c == 9) check("run mid state", state_o, RUN);
        end
        cpu_done = 1'b0;
        check("done state", state_o, DONE);
        check("done run_cyc", run_cyc, 10);
        check("done cpu_reset", cpu_reset, 1);
        check("done word_cnt", word_cnt, 3);
        check("done busy", busy, 0);

        for (int i = 5; i <= 11; i++) apply_vec(i);

        // Timeout: 16 RUN cycles with cpu_done low.
        for (int c = 1; c <= 15; c++) tick();
        check("to pre state", state_o, RUN);
        check("to pre run_cyc", run_cyc, 15);
        tick();
        check("to state", state_o, TIMEOUT);
        check("to run_cyc", run_cyc, 15);
        check("to cpu_reset", cpu_reset, 1);

        // cpu_done on the would-be timeout cycle: DONE wins.
        load_prog(2);
        tick();
        for (int c = 1; c <= 15; c++) tick();
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        check("tie state", state_o, DONE);
        check("tie run_cyc", run_cyc, 16);

        // Overflow with a stray start inside LOAD.
        start = 1'b1;
        tick();
        start = 1'b0;
        got_addr.delete();
        got_data.delete();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 9'h040 + 9'(k);
            in_last  = 1'b0;
            start    = (k == 1);
            tick();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("ovf state", state_o, ERR);
        check("ovf in_ready", in_ready, 0);
        check("ovf word_cnt", word_cnt, 4);
        check("ovf nwrites", got_addr.size(), 4);
        for (int k = 0; k < 4 && k < got_addr.size(); k++) begin
            check($sformatf("ovf addr%0d", k), got_addr[k], k);
            check($sformatf("ovf data%0d", k), got_data[k], 9'h040 + 9'(k));
        end
        tick();
        check("ovf hold state", state_o, ERR);
        check("ovf hold im_we", im_we, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ovf restart state", state_o, LOAD);
        check("ovf restart word_cnt", word_cnt, 0);
        check("ovf restart in_ready", in_ready, 1);

        // Reset after two words of a load.
        in_valid = 1'b1;
        in_data  = 9'h011;
        tick();
        in_data  = 9'h022;
        tick();
        check("rl word_cnt", word_cnt, 2);
        reset   = 1'b0;
        in_data = 9'h033;
        tick();
        check("rl state", state_o, IDLE);
        check("rl im_we", im_we, 0);
        check("rl im_addr", im_addr, 0);
        check("rl im_din", im_din, 0);
        check("rl cpu_reset", cpu_reset, 1);
        check("rl word_cnt", word_cnt, 0);
        reset = 1'b1;
        tick();
        check("rl after im_we", im_we, 0);
        check("rl after state", state_o, IDLE);
        in_valid = 1'b0;

        // Reset during RUN.
        load_prog(1);
        tick();
        tick();
        tick();
        check("rr run_cyc", run_cyc, 2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rr state", state_o, IDLE);
        check("rr cpu_reset", cpu_reset, 1);
        check("rr run_cyc", run_cyc, 0);
        check("rr word_cnt", word_cnt, 0);

        // Randomized programs against the transaction-level model.
        for (int it = 0; it < 40; it++) begin
            n       = $urandom_range(1, T_DEPTH + 1);
            done_at = $urandom_range(1, T_MAXCYC + 4);
            for (int k = 0; k < T_DEPTH; k++) words[k] = 9'($urandom);
            sent = (n > T_DEPTH) ? T_DEPTH : n;

            if (n > T_DEPTH) begin
                e_state = ERR;   e_wc = 9'(T_DEPTH); e_rc = 0; e_run = 0;
            end else if (done_at <= T_MAXCYC) begin
                e_state = DONE;  e_wc = 9'(n); e_rc = 16'(done_at); e_run = done_at;
            end else begin
                e_state = TIMEOUT; e_wc = 9'(n); e_rc = 16'(T_MAXCYC - 1); e_run = T_MAXCYC;
            end

            got_addr.delete();
            got_data.delete();
            run_seen = 0;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int k = 0; k < sent; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_data  = 9'($urandom);
                    tick();
                end
                in_valid = 1'b1;
                in_data  = words[k];
                in_last  = (k == n - 1);
                tick();
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (state_o == RELEASE) begin
                tick();
                for (int c = 1; c <= T_MAXCYC + 8 && state_o == RUN; c++) begin
                    cpu_done = (c == done_at);
                    tick();
                end
                cpu_done = 1'b0;
            end

            check($sformatf("rnd%0d state", it), state_o, e_state);
            check($sformatf("rnd%0d word_cnt", it), word_cnt, e_wc);
            check($sformatf("rnd%0d run_cyc", it), run_cyc, e_rc);
            check($sformatf("rnd%0d run cycles", it), run_seen, e_run);
            check($sformatf("rnd%0d nwrites", it), got_addr.size(), sent);
            nexp = (got_addr.size() < sent) ? got_addr.size() : sent;
            for (int k = 0; k < nexp; k++) begin
                check($sformatf("rnd%0d addr%0d", it, k), got_addr[k], k);
                check($sformatf("rnd%0d data%0d", it, k), got_data[k], words[k]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
